bcd_serial_addsub: RTL and testbench

- Digit-serial, parametrised N-digit packed-BCD adder/subtractor with a start/ready/valid handshake.
- Processes one BCD digit per clock, least significant digit (LSD) first.
- Subtraction uses ten's complement.
- A negative difference gets a second serial pass, so the block returns sign plus magnitude.
- Sits in the decimal arithmetic datapath and replaces the fixed two-digit combinational adder for wide operands.

---
 rtl/bcd_pkg.sv | 31 +++
 rtl/bcd_serial_addsub_digit_step.sv | 32 +++
 rtl/bcd_serial_addsub.sv | 174 +++++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared BCD digit types, constants and helpers for the
//               digit-serial adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } bcd_state_t;

    function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
        return BCD_NINE - d;
    endfunction

    function automatic logic digit_invalid(input bcd_digit_t d);
        return (d > BCD_NINE);
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_serial_addsub_digit_step.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_step
// Description : Single BCD digit add with carry-in and decimal correction.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_step
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] w_sum;

    always_comb begin
        w_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        // Binary sums of 10..19 wrap into the next decade by adding 6 mod 16.
        if (w_sum[4] || (w_sum[3:0] > BCD_NINE)) begin
            s    = w_sum[3:0] + BCD_CORR;
            cout = 1'b1;
        end else begin
            s    = w_sum[3:0];
            cout = 1'b0;
        end
    end

endmodule : bcd_digit_step
`default_nettype wire

// File: rtl/bcd_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_addsub
// Description : Digit-serial N-digit packed-BCD adder/subtractor returning
//               sign plus magnitude, with start/ready/valid handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                ready,
    output logic                valid,
    output logic [4*DIGITS-1:0] result,
    output logic                carry,
    output logic                neg,
    output logic                err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(DIGITS - 1);

    bcd_state_t          r_state;
    logic [4*DIGITS-1:0] r_a;
    logic [4*DIGITS-1:0] r_b;
    logic                r_sub;
    logic                r_c;
    logic                r_err_pend;
    logic [CNT_W-1:0]    r_idx;

    logic [3:0]          w_da;
    logic [3:0]          w_db;
    logic [3:0]          w_dr;
    logic [3:0]          w_step_a;
    logic [3:0]          w_step_b;
    logic [3:0]          w_s;
    logic                w_cout;
    logic                w_last;
    logic                w_in_err;
    logic                w_accept;
    logic [4*DIGITS-1:0] w_b_eff;

    always_comb begin
        w_da = 4'd0;
        w_db = 4'd0;
        w_dr = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == CNT_W'(i)) begin
                w_da = r_a[4*i +: 4];
                w_db = r_b[4*i +: 4];
                w_dr = result[4*i +: 4];
            end
        end
        // NEG reuses the adder as 9's complement + 1 over the stored result.
        w_step_a = (r_state == NEG) ? nines_comp(w_dr) : w_da;
        w_step_b = (r_state == NEG) ? 4'd0 : w_db;
    end

    always_comb begin
        w_in_err = 1'b0;
        w_b_eff  = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_invalid(a[4*i +: 4]) || digit_invalid(b[4*i +: 4])) begin
                w_in_err = 1'b1;
            end
            if (sub) begin
                w_b_eff[4*i +: 4] = nines_comp(b[4*i +: 4]);
            end
        end
    end

    assign w_last   = (r_idx == c_last_idx);
    assign w_accept = start && ready;

    bcd_digit_step u_step (
        .a    (w_step_a),
        .b    (w_step_b),
        .cin  (r_c),
        .s    (w_s),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sub      <= 1'b0;
            r_c        <= 1'b0;
            r_err_pend <= 1'b0;
            r_idx      <= '0;
            ready      <= 1'b1;
            valid      <= 1'b0;
            result     <= '0;
            carry      <= 1'b0;
            neg        <= 1'b0;
            err        <= 1'b0;
        end else if (w_accept) begin
            r_state    <= ADD;
            r_a        <= a;
            r_b        <= w_b_eff;
            r_sub      <= sub;
            r_c        <= sub;
            r_err_pend <= w_in_err;
            r_idx      <= '0;
            ready      <= 1'b0;
            valid      <= 1'b0;
            result     <= '0;
            carry      <= 1'b0;
            neg        <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (r_state)
                ADD: begin
                    if (r_err_pend) begin
                        err     <= 1'b1;
                        r_state <= DONE;
                        ready   <= 1'b1;
                        valid   <= 1'b1;
                    end else begin
                        for (int i = 0; i < DIGITS; i++) begin
                            if (r_idx == CNT_W'(i)) begin
                                result[4*i +: 4] <= w_s;
                            end
                        end
                        r_c   <= w_cout;
                        r_idx <= r_idx + 1'b1;
                        if (w_last) begin
                            carry <= w_cout;
                            r_idx <= '0;
                            // No end-around carry on a subtract means a < b.
                            if (r_sub && !w_cout) begin
                                r_state <= NEG;
                                r_c     <= 1'b1;
                            end else begin
                                r_state <= DONE;
                                ready   <= 1'b1;
                                valid   <= 1'b1;
                            end
                        end
                    end
                end
                NEG: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == CNT_W'(i)) begin
                            result[4*i +: 4] <= w_s;
                        end
                    end
                    r_c   <= w_cout;
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_idx   <= '0;
                        neg     <= 1'b1;
                        r_state <= DONE;
                        ready   <= 1'b1;
                        valid   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

endmodule : bcd_serial_addsub
`default_nettype wire

// File: tb/tb_bcd_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_serial_addsub
// Description : Self-checking bench: directed vector table, handshake/reset
//               sequences and randomized operations against an integer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int LIMIT  = 3 * DIGITS + 4;

    logic         clk = 1'b0;
    logic         nrst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         valid;
    logic [W-1:0] result;
    logic         carry;
    logic         neg;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk    (clk),
        .nrst   (nrst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .valid  (valid),
        .result (result),
        .carry  (carry),
        .neg    (neg),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         c;
        logic         n;
        logic         e;
        int           lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference: decimal arithmetic on plain integers.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                         output logic [W-1:0] r, output logic c, output logic n,
                         output logic e, output int lat);
        int va, vb, lim;
        e = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) e = 1'b1;
        r = '0; c = 1'b0; n = 1'b0; lat = DIGITS;
        if (e) begin
            lat = 1;
            return;
        end
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        va = bcd2int(ma);
        vb = bcd2int(mb);
        if (!ms) begin
            r = int2bcd((va + vb) % lim);
            c = (va + vb) >= lim;
        end else if (va >= vb) begin
            r = int2bcd(va - vb);
            c = 1'b1;
        end else begin
            r = int2bcd(vb - va);
            n = 1'b1;
            lat = 2 * DIGITS;
        end
    endtask

    task automatic wait_valid(inout int lat);
        while (!valid && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: valid not seen within %0d cycles", LIMIT);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                          output logic [W-1:0] r, output logic c, output logic n,
                          output logic e, output int lat);
        @(negedge clk);
        check("ready_before_start", 32'(ready), 32'd1);
        a = ta; b = tb_; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("valid_drop_after_accept", 32'(valid), 32'd0);
        lat = 0;
        wait_valid(lat);
        r = result; c = carry; n = neg; e = err;
    endtask

    initial begin
        logic [W-1:0] r, mr, ra, rb;
        logic         c, n, e, mc, mn, me, rs;
        int           lat, mlat;

        vecs[0] = '{16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4};
        vecs[1] = '{16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, 1'b0, 4};
        vecs[2] = '{16'h1234, 16'h5000, 1'b1, 16'h3766, 1'b0, 1'b1, 1'b0, 8};
        vecs[3] = '{16'h0042, 16'h0042, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4};
        vecs[4] = '{16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 4};
        vecs[5] = '{16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
        vecs[6] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 4};

        nrst = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  32'(ready),  32'd1);
        check("rst_valid",  32'(valid),  32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags",  32'({carry, neg, err}), 32'd0);
        @(negedge clk) nrst = 1'b1;

        // Directed table; consecutive entries also exercise back-to-back starts in DONE.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, r, c, n, e, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
            check($sformatf("vec%0d_carry", i), 32'(c), 32'(vecs[i].c));
            check($sformatf("vec%0d_neg", i), 32'(n), 32'(vecs[i].n));
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].e));
        end

        // Start pulse while busy must be ignored.
        @(negedge clk);
        a = 16'h5000; b = 16'h1234; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'h9999; b = 16'h0000; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        wait_valid(lat);
        check("busy_latency", 32'(lat), 32'd4);
        check("busy_result", 32'(result), 32'h3766);
        check("busy_flags", 32'({carry, neg, err}), 32'b100);

        // Reset mid-operation discards partial work.
        @(negedge clk);
        a = 16'h1234; b = 16'h5000; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk) nrst = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready",  32'(ready),  32'd1);
        check("midrst_valid",  32'(valid),  32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_flags",  32'({carry, neg, err}), 32'd0);
        @(negedge clk) nrst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_stays_idle", 32'({ready, valid}), 32'b10);

        // Randomized operations against the integer model.
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < DIGITS; i++) begin
                ra[4*i +: 4] = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(10, 15))
                                                            : 4'($urandom_range(0, 9));
                rb[4*i +: 4] = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(10, 15))
                                                            : 4'($urandom_range(0, 9));
            end
            if (k % 10 == 3) rb = ra;
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, mr, mc, mn, me, mlat);
            run_op(ra, rb, rs, r, c, n, e, lat);
            check($sformatf("rnd%0d_latency", k), 32'(lat), 32'(mlat));
            check($sformatf("rnd%0d_result", k), 32'(r), 32'(mr));
            check($sformatf("rnd%0d_flags", k), 32'({c, n, e}), 32'({mc, mn, me}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bcd_serial_addsub
`default_nettype wire
